// File: rtl/aggr_pkg.sv
// Shared types and default geometry for the cost-aggregation frame sequencer.
package aggr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_IMAGE_ROW = 200;
    localparam int DEF_IMAGE_COL = 400;
    localparam int DEF_COST_W    = 864;
    localparam int RC_W          = 10;

    function automatic int addr_w(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

    localparam int DEF_ADDR_W = addr_w(DEF_IMAGE_ROW, DEF_IMAGE_COL);

endpackage

// File: rtl/aggr_raster_cnt.sv
// Raster-order row/column counter with a linear address that tracks row*COLS+col.
module aggr_raster_cnt
    import aggr_pkg::*;
#(
    parameter int ROWS   = DEF_IMAGE_ROW,
    parameter int COLS   = DEF_IMAGE_COL,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [RC_W-1:0]   row,
    output logic [RC_W-1:0]   col,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [RC_W-1:0] ROW_MAX = RC_W'(ROWS - 1);
    localparam logic [RC_W-1:0] COL_MAX = RC_W'(COLS - 1);

    logic [RC_W-1:0]   row_r;
    logic [RC_W-1:0]   col_r;
    logic [ADDR_W-1:0] addr_r;
    logic              last_s;

    assign last_s = (row_r == ROW_MAX) && (col_r == COL_MAX);

    // Position registers; the last pixel wraps straight back to the frame origin.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row_r  <= {RC_W{1'b0}};
            col_r  <= {RC_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (inc) begin
            if (col_r == COL_MAX) begin
                col_r <= {RC_W{1'b0}};
                row_r <= last_s ? {RC_W{1'b0}} : row_r + {{(RC_W-1){1'b0}}, 1'b1};
            end else begin
                col_r <= col_r + {{(RC_W-1){1'b0}}, 1'b1};
            end
            addr_r <= last_s ? {ADDR_W{1'b0}} : addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    assign row  = row_r;
    assign col  = col_r;
    assign addr = addr_r;
    assign last = last_s;

endmodule

// File: rtl/aggr_stream_ctrl.sv
// Frame sequencer: feeds cost memory reads to delay_aggr in raster order and
// tracks returned aggregate outputs to flag frame completion.
module aggr_stream_ctrl
    import aggr_pkg::*;
#(
    parameter int IMAGE_ROW = DEF_IMAGE_ROW,
    parameter int IMAGE_COL = DEF_IMAGE_COL,
    parameter int COST_W    = DEF_COST_W,
    parameter int ADDR_W    = addr_w(IMAGE_ROW, IMAGE_COL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              pause,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [COST_W-1:0] mem_rdata,
    output logic              en_out,
    output logic [COST_W-1:0] cost_out,
    output logic [RC_W-1:0]   row_out,
    output logic [RC_W-1:0]   col_out,
    input  logic              valid_in,
    output logic              busy,
    output logic              frame_done,
    output logic [4:0]        frame_cnt,
    output logic              err_ovf
);

    localparam int OUT_W = ADDR_W + 1;

    state_t            state_r, state_nx_s;
    logic              issue_s, ret_s, none_out_s, frame_end_s, drain_done_s;
    logic [RC_W-1:0]   fc_row_s, fc_col_s, oc_row_s, oc_col_s;
    logic [ADDR_W-1:0] fc_addr_s, oc_addr_s;
    logic              fc_last_s, oc_last_s;
    logic              en_r, done_r, ovf_r;
    logic [RC_W-1:0]   row_r, col_r;
    logic [4:0]        cnt_r;
    logic [OUT_W-1:0]  outst_r;
    logic              unused_s;

    assign issue_s      = (state_r == ST_FEED) && !pause;
    assign none_out_s   = (outst_r == {OUT_W{1'b0}});
    // A return with nothing in flight is an error and must not move the output raster.
    assign ret_s        = valid_in && !none_out_s;
    assign frame_end_s  = ret_s && oc_last_s;
    assign drain_done_s = frame_end_s && (outst_r == {{(OUT_W-1){1'b0}}, 1'b1});

    aggr_raster_cnt #(.ROWS(IMAGE_ROW), .COLS(IMAGE_COL), .ADDR_W(ADDR_W)) u_feed_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_r == ST_IDLE),
        .inc (issue_s),
        .row (fc_row_s),
        .col (fc_col_s),
        .addr(fc_addr_s),
        .last(fc_last_s)
    );

    aggr_raster_cnt #(.ROWS(IMAGE_ROW), .COLS(IMAGE_COL), .ADDR_W(ADDR_W)) u_out_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (ret_s),
        .row (oc_row_s),
        .col (oc_col_s),
        .addr(oc_addr_s),
        .last(oc_last_s)
    );

    assign unused_s = ^{oc_row_s, oc_col_s, oc_addr_s};

    // Next-state decode; cont only matters on the last pixel of a frame.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nx_s = ST_FEED;
                else       state_nx_s = ST_IDLE;
            end
            ST_FEED: begin
                if (issue_s && fc_last_s && !cont) state_nx_s = ST_DRAIN;
                else                               state_nx_s = ST_FEED;
            end
            ST_DRAIN: begin
                if (drain_done_s) state_nx_s = ST_IDLE;
                else              state_nx_s = ST_DRAIN;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nx_s;
    end

    // Feed-side alignment stage plus output-side bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r    <= 1'b0;
            row_r   <= {RC_W{1'b0}};
            col_r   <= {RC_W{1'b0}};
            done_r  <= 1'b0;
            cnt_r   <= 5'd0;
            ovf_r   <= 1'b0;
            outst_r <= {OUT_W{1'b0}};
        end else begin
            en_r   <= issue_s;
            row_r  <= fc_row_s;
            col_r  <= fc_col_s;
            done_r <= frame_end_s;
            if (frame_end_s) cnt_r <= cnt_r + 5'd1;
            if (valid_in && none_out_s) ovf_r <= 1'b1;
            case ({issue_s, ret_s})
                2'b10:   outst_r <= outst_r + {{(OUT_W-1){1'b0}}, 1'b1};
                2'b01:   outst_r <= outst_r - {{(OUT_W-1){1'b0}}, 1'b1};
                default: outst_r <= outst_r;
            endcase
        end
    end

    assign mem_rd_en  = issue_s;
    assign mem_addr   = fc_addr_s;
    assign en_out     = en_r;
    assign cost_out   = mem_rdata;
    assign row_out    = row_r;
    assign col_out    = col_r;
    assign busy       = (state_r != ST_IDLE);
    assign frame_done = done_r;
    assign frame_cnt  = cnt_r;
    assign err_ovf    = ovf_r;

endmodule

// File: tb/tb_aggr_stream_ctrl.sv
// Scoreboard bench for aggr_stream_ctrl on a 3x4 frame with a 5-cycle return path.
module tb_aggr_stream_ctrl;

    localparam int ROWS = 3;
    localparam int COLS = 4;
    localparam int NPIX = ROWS * COLS;
    localparam int CW   = 16;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst, start, cont, pause, vin_force;
    logic          mem_rd_en, en_out, valid_in, busy, frame_done, err_ovf;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_rdata, cost_out;
    logic [9:0]    row_out, col_out;
    logic [4:0]    frame_cnt;
    logic [4:0]    vpipe;

    typedef struct {int addr; int gap;} iss_t;
    typedef struct {int addr; int row; int col; int gap;} pix_t;
    typedef struct {int cnt; int rel; int busy;} done_t;

    iss_t  iss_q[$];
    pix_t  pix_q[$];
    done_t done_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;

    always #5 clk = ~clk;

    aggr_stream_ctrl #(.IMAGE_ROW(ROWS), .IMAGE_COL(COLS), .COST_W(CW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .pause(pause),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .en_out(en_out), .cost_out(cost_out), .row_out(row_out), .col_out(col_out),
        .valid_in(valid_in), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .err_ovf(err_ovf)
    );

    function automatic logic [CW-1:0] cost_of(input int a);
        return 16'hC3A0 ^ 16'(a * 37);
    endfunction

    assign valid_in = vpipe[4] | vin_force;

    // Cost memory with one-cycle read latency and a fixed-latency aggregation return path.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            vpipe     <= 5'd0;
            mem_rdata <= '0;
        end else begin
            vpipe <= {vpipe[3:0], en_out};
            if (mem_rd_en) mem_rdata <= cost_of(int'(mem_addr));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an issue, a pixel or a frame end.
    initial begin : monitor
        int last_iss, last_en;
        logic vin_prev;
        iss_t  ie;
        pix_t  pe;
        done_t de;
        last_iss = -1;
        last_en  = -1;
        vin_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_iss = -1;
                last_en  = -1;
                vin_prev = 1'b0;
            end else begin
                if (mem_rd_en) begin
                    if (iss_q.size() == 0) chk("unexpected_issue", int'(mem_addr), -1);
                    else begin
                        ie = iss_q.pop_front();
                        chk("mem_addr", int'(mem_addr), ie.addr);
                        if (ie.gap != 0) chk("issue_gap", cyc - last_iss, ie.gap);
                    end
                    last_iss = cyc;
                end
                if (en_out) begin
                    if (pix_q.size() == 0) chk("unexpected_en_out", int'(row_out), -1);
                    else begin
                        pe = pix_q.pop_front();
                        chk("row_out", int'(row_out), pe.row);
                        chk("col_out", int'(col_out), pe.col);
                        chk("cost_out", int'(cost_out), int'(cost_of(pe.addr)));
                        if (pe.gap != 0) chk("en_out_gap", cyc - last_en, pe.gap);
                    end
                    last_en = cyc;
                end
                if (frame_done) begin
                    if (done_q.size() == 0) chk("unexpected_frame_done", int'(frame_cnt), -1);
                    else begin
                        de = done_q.pop_front();
                        chk("frame_cnt", int'(frame_cnt), de.cnt);
                        chk("frame_done_cycle", cyc - t0, de.rel);
                        chk("busy_at_done", int'(busy), de.busy);
                        chk("done_after_valid", int'(vin_prev), 1);
                    end
                end
                vin_prev = valid_in;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pix(input int i, input int first_gap, input int pidx, input int plen,
                            input bit with_pix);
        iss_t ie;
        pix_t pe;
        int   g;
        g = (i == 0) ? first_gap : ((i == pidx) ? 1 + plen : 1);
        ie.addr = i;
        ie.gap  = g;
        iss_q.push_back(ie);
        if (with_pix) begin
            pe.addr = i;
            pe.row  = i / COLS;
            pe.col  = i % COLS;
            pe.gap  = g;
            pix_q.push_back(pe);
        end
    endtask

    task automatic push_frame(input int first_gap, input int pidx, input int plen);
        for (int i = 0; i < NPIX; i++) push_pix(i, first_gap, pidx, plen, 1'b1);
    endtask

    task automatic push_done(input int cnt, input int rel, input int bsy);
        done_t de;
        de.cnt  = cnt;
        de.rel  = rel;
        de.busy = bsy;
        done_q.push_back(de);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        t0 = cyc;
        tick(1);
        start = 1'b0;
        chk("first_issue_rd_en", int'(mem_rd_en), 1);
        chk("first_issue_busy", int'(busy), 1);
    endtask

    task automatic check_reset_vals();
        chk("rst_mem_rd_en", int'(mem_rd_en), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_en_out", int'(en_out), 0);
        chk("rst_row_out", int'(row_out), 0);
        chk("rst_col_out", int'(col_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_err_ovf", int'(err_ovf), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        check_reset_vals();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((done_q.size() != 0 || busy) && n < 300) begin
            tick(1);
            n++;
        end
        chk(name, int'(n < 300), 1);
    endtask

    initial begin : stimulus
        rst = 1'b1; start = 1'b0; cont = 1'b0; pause = 1'b0; vin_force = 1'b0;
        do_reset();

        // single frame, with a second start mid-frame that must be ignored
        push_frame(0, -1, 0);
        push_done(1, 19, 0);
        pulse_start();
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle("single_frame_timeout");
        chk("single_frame_cnt", int'(frame_cnt), 1);

        // stray return while idle
        vin_force = 1'b1;
        tick(1);
        vin_force = 1'b0;
        chk("ovf_set", int'(err_ovf), 1);
        tick(3);
        chk("ovf_sticky", int'(err_ovf), 1);
        chk("ovf_no_frame", int'(frame_cnt), 1);

        // four-cycle pause at pixel 5
        push_frame(0, 5, 4);
        push_done(2, 23, 0);
        pulse_start();
        tick(5);
        pause = 1'b1;
        tick(4);
        pause = 1'b0;
        wait_idle("pause_frame_timeout");
        chk("pause_frame_cnt", int'(frame_cnt), 2);
        chk("ovf_held_until_rst", int'(err_ovf), 1);

        do_reset();

        // three continuous frames, cont dropped during the third
        cont = 1'b1;
        push_frame(0, -1, 0);
        push_frame(1, -1, 0);
        push_frame(1, -1, 0);
        push_done(1, 19, 1);
        push_done(2, 31, 1);
        push_done(3, 43, 0);
        pulse_start();
        tick(29);
        cont = 1'b0;
        wait_idle("cont_timeout");
        chk("cont_frame_cnt", int'(frame_cnt), 3);

        // reset while pixel 7 is being issued, then a clean restart
        for (int i = 0; i < 7; i++) push_pix(i, 0, -1, 0, (i < 6));
        pulse_start();
        tick(7);
        rst = 1'b1;
        tick(1);
        check_reset_vals();
        rst = 1'b0;
        push_frame(0, -1, 0);
        push_done(1, 19, 0);
        pulse_start();
        wait_idle("restart_timeout");
        chk("restart_frame_cnt", int'(frame_cnt), 1);

        tick(2);
        chk("iss_q_drained", iss_q.size(), 0);
        chk("pix_q_drained", pix_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
